i2s_slave: RTL and testbench

I2S slave transceiver for a codec or ADC/DAC that drives its own bit clock (`sclk`) and word clock (`lrclk`). Everything runs in the system clock domain: the slave oversamples the external clocks and serial data, recovers frame timing, and de-serialises the receive stream into stereo samples. In the same frames it serialises the transmit stream. It is the clock-consuming counterpart of the existing 12.288 MHz I2S master path, and it needs no second clock domain and no async FIFO.

---
 rtl/i2s_slave.sv | 175 +++++++++++++++++
 tb/tb_i2s_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave.sv
// I2S slave transceiver: oversamples the codec's sclk/lrclk/sd in the i_clk domain,
// de-serialises the received stereo pair and serialises the transmit pair in the same frames.
//
// state  | meaning
// IDLE   | no slot boundary seen since reset; partial slot is discarded
// WAIT_L | boundary seen, waiting for a left commit
// GOT_L  | left sample stored, waiting for the matching right commit
module i2s_slave #(
    parameter int DATA_BIT = 24
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_lrclk,
    input  logic                i_rx_sd,
    input  logic [DATA_BIT-1:0] i_audio_l,
    input  logic [DATA_BIT-1:0] i_audio_r,
    input  logic                i_audio_valid,
    output logic [DATA_BIT-1:0] o_audio_l,
    output logic [DATA_BIT-1:0] o_audio_r,
    output logic                o_audio_valid,
    output logic                o_audio_ready,
    output logic                o_locked,
    output logic                o_tx_sd
);
    localparam int CNT_W = $clog2(DATA_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        GOT_L  = 2'd2
    } state_t;

    state_t state, state_next;

    // [0],[1] synchroniser stages, [2] history register
    logic [2:0]          sclk_sync, lrclk_sync, sd_sync;
    logic                rise, fall;
    logic                ws;
    logic                ws_new, sd_bit, boundary, left_start, right_start;
    logic [DATA_BIT-1:0] rx_sr, rx_shift, rx_aligned, rx_l;
    logic [CNT_W-1:0]    bit_cnt, cnt_next;
    logic                commit_l, pair_done;
    logic [DATA_BIT-1:0] hold_l, hold_r, cur_l, cur_r, tx_sr;

    assign ws_new      = lrclk_sync[2];
    assign sd_bit      = sd_sync[2];
    assign boundary    = rise && (ws_new != ws);
    assign left_start  = boundary && !ws_new;
    assign right_start = boundary && ws_new;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync  <= '0;
            lrclk_sync <= '0;
            sd_sync    <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], i_sclk};
            lrclk_sync <= {lrclk_sync[1:0], i_lrclk};
            sd_sync    <= {sd_sync[1:0], i_rx_sd};
            rise       <= sclk_sync[1] & ~sclk_sync[2];
            fall       <= ~sclk_sync[1] & sclk_sync[2];
        end
    end

    // Short slots leave fewer than DATA_BIT bits; left-align them with zero LSBs.
    always_comb begin
        rx_shift = rx_sr;
        cnt_next = bit_cnt;
        if (bit_cnt < CNT_FULL) begin
            rx_shift = {rx_sr[DATA_BIT-2:0], sd_bit};
            cnt_next = bit_cnt + CNT_W'(1);
        end
        rx_aligned = rx_shift << (CNT_FULL - cnt_next);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit_l   = 1'b0;
        pair_done  = 1'b0;
        if (boundary) begin
            case (state)
                IDLE: state_next = WAIT_L;
                WAIT_L: begin
                    if (!ws) begin
                        commit_l   = 1'b1;
                        state_next = GOT_L;
                    end
                end
                GOT_L: begin
                    if (!ws) begin
                        commit_l = 1'b1;
                    end else begin
                        pair_done  = 1'b1;
                        state_next = WAIT_L;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ws            <= 1'b0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            rx_l          <= '0;
            o_audio_l     <= '0;
            o_audio_r     <= '0;
            o_audio_valid <= 1'b0;
            o_locked      <= 1'b0;
        end else begin
            o_audio_valid <= pair_done;
            if (rise) begin
                ws <= ws_new;
                if (boundary) begin
                    rx_sr   <= '0;
                    bit_cnt <= '0;
                end else begin
                    rx_sr   <= rx_shift;
                    bit_cnt <= cnt_next;
                end
            end
            if (commit_l) begin
                rx_l <= rx_aligned;
            end
            if (pair_done) begin
                o_audio_l <= rx_l;
                o_audio_r <= rx_aligned;
                o_locked  <= 1'b1;
            end
        end
    end

    // Snapshot uses the pre-edge hold values, so a same-cycle write lands in the next frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold_l        <= '0;
            hold_r        <= '0;
            cur_l         <= '0;
            cur_r         <= '0;
            tx_sr         <= '0;
            o_tx_sd       <= 1'b0;
            o_audio_ready <= 1'b0;
        end else begin
            o_audio_ready <= left_start;
            if (i_audio_valid) begin
                hold_l <= i_audio_l;
                hold_r <= i_audio_r;
            end
            if (left_start) begin
                cur_l <= hold_l;
                cur_r <= hold_r;
                tx_sr <= hold_l;
            end else if (right_start) begin
                tx_sr <= cur_r;
            end else if (fall) begin
                o_tx_sd <= tx_sr[DATA_BIT-1];
                tx_sr   <= {tx_sr[DATA_BIT-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_i2s_slave.sv
// Bench for i2s_slave: drives a codec-style I2S stream (sclk period 32 i_clk),
// scoreboards received pairs and the serial transmit stream.
module tb_i2s_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        sd_drv = 1'b0;
    logic        loopback = 1'b0;
    logic [23:0] a_l = '0;
    logic [23:0] a_r = '0;
    logic        a_valid = 1'b0;
    logic [23:0] o_l, o_r;
    logic        o_valid, o_ready, o_locked, o_tx;
    logic        rx_sd;

    assign rx_sd = loopback ? o_tx : sd_drv;

    i2s_slave #(.DATA_BIT(24)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_sclk        (sclk),
        .i_lrclk       (lrclk),
        .i_rx_sd       (rx_sd),
        .i_audio_l     (a_l),
        .i_audio_r     (a_r),
        .i_audio_valid (a_valid),
        .o_audio_l     (o_l),
        .o_audio_r     (o_r),
        .o_audio_valid (o_valid),
        .o_audio_ready (o_ready),
        .o_locked      (o_locked),
        .o_tx_sd       (o_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        int          pos;
        logic [23:0] l;
        logic [23:0] r;
    } strobe_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          valid_cnt = 0;
    int          ready_cnt = 0;
    logic [47:0] rxq[$];
    logic [23:0] txq[$];
    strobe_t     strq[$];
    logic [47:0] mon_e;
    int          tx_pos = 0;
    int          tx_len = 32;
    bit          tx_chk = 1'b0;
    logic [23:0] tx_word = '0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_ready) ready_cnt++;
        if (o_valid) begin
            valid_cnt++;
            if (rxq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rx_unexpected: got valid with %h/%h expected no pulse", o_l, o_r);
            end else begin
                mon_e = rxq.pop_front();
                check("rx_left", o_l, mon_e[47:24]);
                check("rx_right", o_r, mon_e[23:0]);
                check("locked_at_valid", {23'd0, o_locked}, 24'd1);
            end
        end
    end

    // Codec side samples the transmit line on its own rising sclk edge.
    always @(posedge sclk) begin
        if (tx_chk) begin
            if (tx_pos == 0) tx_word = '0;
            if (tx_pos < 24) tx_word = {tx_word[22:0], o_tx};
            if (tx_pos == tx_len - 1) begin
                if (txq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL tx_unexpected: got slot %h expected none", tx_word);
                end else begin
                    check("tx_slot", tx_word, txq.pop_front());
                end
            end
        end
    end

    // One bit period: falling edge, 16 i_clk low, rising edge, 16 i_clk high.
    // A scheduled strobe lands in the cycle the DUT acts on this rising edge.
    task automatic send_bit(input logic ws, input logic sd, input int slot, input int pos, input int len);
        @(negedge clk);
        sclk   = 1'b0;
        lrclk  = ws;
        sd_drv = sd;
        repeat (16) @(negedge clk);
        tx_pos = pos;
        tx_len = len;
        sclk   = 1'b1;
        if (strq.size() > 0 && strq[0].slot == slot && strq[0].pos == pos) begin
            repeat (3) @(negedge clk);
            a_l     = strq[0].l;
            a_r     = strq[0].r;
            a_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0;
            strq.delete(0);
            repeat (11) @(negedge clk);
        end else begin
            repeat (15) @(negedge clk);
        end
    endtask

    // Word select leads the slot by one bit (I2S delay).
    task automatic send_slot(input int slot, input int len, input int dbits, input logic [23:0] data,
                             input int from, input int to);
        logic ws;
        logic b;
        for (int p = from; p <= to; p++) begin
            ws = (p == len - 1) ? (slot == 0) : (slot == 1);
            b  = (p < dbits) ? data[dbits-1-p] : 1'b0;
            send_bit(ws, b, slot, p, len);
        end
    endtask

    task automatic send_frame(input int len, input logic [23:0] l, input logic [23:0] r,
                              input bit push, input logic [23:0] el, input logic [23:0] er,
                              input bit chk, input logic [23:0] tl, input logic [23:0] tr);
        int dbits;
        int r0;
        int v0;
        dbits = (len < 24) ? len : 24;
        r0 = ready_cnt;
        v0 = valid_cnt;
        if (push) rxq.push_back({el, er});
        tx_chk = chk;
        if (chk) begin
            txq.push_back(tl);
            txq.push_back(tr);
        end
        send_slot(0, len, dbits, l, 0, len - 1);
        send_slot(1, len, dbits, r, 0, len - 1);
        check("ready_per_frame", 24'(ready_cnt - r0), 24'd1);
        check("valid_per_frame", 24'(valid_cnt - v0), push ? 24'd1 : 24'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_audio_l"}, o_l, 24'd0);
        check({tag, "_audio_r"}, o_r, 24'd0);
        check({tag, "_valid"}, {23'd0, o_valid}, 24'd0);
        check({tag, "_ready"}, {23'd0, o_ready}, 24'd0);
        check({tag, "_locked"}, {23'd0, o_locked}, 24'd0);
        check({tag, "_tx_sd"}, {23'd0, o_tx}, 24'd0);
    endtask

    initial begin
        int v0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Codec frames plus transmit ordering: two writes in F1, one on the F2 left-start cycle.
        strq.push_back('{0, 5, 24'h000001, 24'h000002});
        strq.push_back('{1, 5, 24'h000003, 24'h000004});
        send_frame(32, 24'h800001, 24'h7FFFFF, 1'b0, 24'h0, 24'h0, 1'b1, 24'h000000, 24'h000000);
        check("locked_before_first_pair", {23'd0, o_locked}, 24'd0);
        strq.push_back('{1, 31, 24'h000005, 24'h000006});
        send_frame(32, 24'h800001, 24'h7FFFFF, 1'b1, 24'h800001, 24'h7FFFFF, 1'b1, 24'h000003, 24'h000004);
        send_frame(32, 24'h123456, 24'hFEDCBA, 1'b1, 24'h123456, 24'hFEDCBA, 1'b1, 24'h000003, 24'h000004);
        send_frame(32, 24'h000001, 24'hFFFFFF, 1'b1, 24'h000001, 24'hFFFFFF, 1'b1, 24'h000005, 24'h000006);

        // 16-bit slots are left-aligned into 24 bits.
        send_frame(16, 24'h00ABCD, 24'h001234, 1'b1, 24'hABCD00, 24'h123400, 1'b0, 24'h0, 24'h0);
        send_frame(16, 24'h00FFFF, 24'h000001, 1'b1, 24'hFFFF00, 24'h000100, 1'b0, 24'h0, 24'h0);

        // sclk held high for 1000 cycles.
        v0 = valid_cnt;
        repeat (1000) @(negedge clk);
        check("clock_stop_no_valid", 24'(valid_cnt - v0), 24'd0);
        send_frame(32, 24'h5A5A5A, 24'hC3C3C3, 1'b1, 24'h5A5A5A, 24'hC3C3C3, 1'b1, 24'h000005, 24'h000006);

        // Reset in the middle of the right slot.
        tx_chk = 1'b0;
        send_slot(0, 32, 24, 24'h111111, 0, 31);
        send_slot(1, 32, 24, 24'h999999, 0, 15);
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_slot(1, 32, 24, 24'h999999, 16, 31);
        strq.push_back('{0, 5, 24'h000007, 24'h000008});
        send_frame(32, 24'h222222, 24'h333333, 1'b1, 24'h222222, 24'h333333, 1'b0, 24'h0, 24'h0);
        send_frame(32, 24'h444444, 24'h555555, 1'b1, 24'h444444, 24'h555555, 1'b1, 24'h000007, 24'h000008);

        // Transmit looped back into receive.
        loopback = 1'b1;
        strq.push_back('{0, 5, 24'hA5A5A5, 24'h3C3C3C});
        send_frame(32, 24'h0, 24'h0, 1'b1, 24'h000007, 24'h000008, 1'b1, 24'h000007, 24'h000008);
        send_frame(32, 24'h0, 24'h0, 1'b1, 24'hA5A5A5, 24'h3C3C3C, 1'b1, 24'hA5A5A5, 24'h3C3C3C);
        send_frame(32, 24'h0, 24'h0, 1'b1, 24'hA5A5A5, 24'h3C3C3C, 1'b1, 24'hA5A5A5, 24'h3C3C3C);
        tx_chk = 1'b0;

        repeat (8) @(negedge clk);
        check("rx_pairs_outstanding", 24'(rxq.size()), 24'd0);
        check("tx_slots_outstanding", 24'(txq.size()), 24'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
